mux4to1_sched: RTL and testbench

Digital sequencer and round-robin arbiter for the two-stage adiabatic `mux4to1` datapath. It generates the four-phase power-clock codes for stage 0 (`clkpos`/`clkneg`) and stage 1 (`clkpos1`/`clkneg1`), which lags stage 0 by one phase. It shares the mux among N requesters and holds `in0`/`in1` stable across each stage's full evaluate-hold-recover window. It sits between the MIPS25 control logic and the analog power-clock generator.

---
 rtl/mux_sched_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/mux4to1_sched.sv | 186 ++++++++++++++++++
 tb/tb_mux4to1_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared types and helpers for the mux4to1 power-clock sequencer.
//   phase_e     : adiabatic power-clock phase codes (WAIT/EVAL/HOLD/RECOVER)
//   state_e     : sequencer state (IDLE parked, RUN ticking)
//   phase_next(): next phase in the four-phase rotation
//   phase_prev(): previous phase; stage 1 runs one phase behind stage 0
package mux_sched_pkg;

    typedef enum logic [1:0] {
        PhWait    = 2'd0,
        PhEval    = 2'd1,
        PhHold    = 2'd2,
        PhRecover = 2'd3
    } phase_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic phase_e phase_next(input phase_e p);
        logic [1:0] n;
        n = 2'(p) + 2'd1;
        return phase_e'(n);
    endfunction

    function automatic phase_e phase_prev(input phase_e p);
        logic [1:0] n;
        n = 2'(p) - 2'd1;
        return phase_e'(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : N request lines
//   advance    : commit the current grant; pointer moves past the winner
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted requester
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] idx;
    logic            found;

    // (base + off) mod N for base < N and off < N
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IdxW'(s);
    endfunction

    // Scan from the pointer upward; the first active request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = wrap_add(rr_q, k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (advance && found) begin
            rr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/mux4to1_sched.sv
// mux4to1_sched: power-clock sequencer and round-robin arbiter for the two-stage
// adiabatic mux4to1. Stage 0 phases on pc0, stage 1 lags one phase on pc1; the
// mux selects in0/in1 are held across each stage's evaluate-hold-recover window.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester request (N)
//   req_sel    : per-requester {in1,in0} select, requester i at [2i+1:2i]
//   req_ready  : one-hot grant, only on accept cycles
//   in0, in1   : stage-0 / stage-1 mux selects
//   pc0, pc1   : stage-0 / stage-1 phase codes (0 WAIT, 1 EVAL, 2 HOLD, 3 RECOVER)
//   out_valid  : one-cycle pulse on the first cycle of stage-1 HOLD
//   out_id     : requester id of the result, held between pulses
//   busy       : an operation is in flight
// Build option: define MUXSCHED_IDLE_PARK_EN to park the power clocks at WAIT in
// an IDLE state when there is no work; otherwise phases free-run from reset.
module mux4to1_sched
    import mux_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned P = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [2*N-1:0]       req_sel,
    output logic [N-1:0]         req_ready,
    output logic                 in0,
    output logic                 in1,
    output logic [1:0]           pc0,
    output logic [1:0]           pc1,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_id,
    output logic                 busy
);

    localparam int unsigned    IdxW   = $clog2(N);
    localparam int unsigned    CntW   = (P > 1) ? $clog2(P) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(P - 1);

`ifdef MUXSCHED_IDLE_PARK_EN
    localparam state_e StReset = StIdle;
`else
    localparam state_e StReset = StRun;
`endif

    state_e          state_q, state_d;
    phase_e          pc0_q, pc0_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in0_q, in0_d;
    logic            in1_q, in1_d;
    logic            sel1_q, sel1_d;
    logic [IdxW-1:0] id_q, id_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [IdxW-1:0] out_id_q, out_id_d;

    logic            tick;
    logic            accept_win;
    logic            accept;
    logic [N-1:0]    grant;
    logic [IdxW-1:0] grant_idx;
    logic [1:0]      sel_pair;

    assign tick = (state_q == StRun) && (cnt_q == CntMax);

`ifdef MUXSCHED_IDLE_PARK_EN
    assign accept_win = (state_q == StIdle) || (tick && (pc0_q == PhWait));
`else
    assign accept_win = tick && (pc0_q == PhWait);
`endif

    assign accept = accept_win && (|req_valid);

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_pair = req_sel[2*int'(grant_idx) +: 2];

    // Phase sequencer
    always_comb begin
        state_d = state_q;
        pc0_d   = pc0_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    pc0_d   = PhEval;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (tick) begin
                    cnt_d = '0;
                    pc0_d = phase_next(pc0_q);
`ifdef MUXSCHED_IDLE_PARK_EN
                    // Stage 1 finishes RECOVER with this WAIT, so parking is safe.
                    if ((pc0_q == PhWait) && !accept) begin
                        state_d = StIdle;
                        pc0_d   = PhWait;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    // Select capture and completion tracking. Ops are 4P apart, so one slot of
    // captured state is enough; busy_q marks whether the current slot is real.
    always_comb begin
        in0_d       = in0_q;
        in1_d       = in1_q;
        sel1_d      = sel1_q;
        id_d        = id_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;

        if (tick && (pc0_q == PhWait)) begin
            busy_d = 1'b0;
        end
        // Stage 1 enters EVAL as stage 0 leaves EVAL.
        if (tick && (pc0_q == PhEval) && busy_q) begin
            in1_d = sel1_q;
        end
        // Stage 1 enters HOLD as stage 0 leaves HOLD.
        if (tick && (pc0_q == PhHold) && busy_q) begin
            out_valid_d = 1'b1;
            out_id_d    = id_q;
        end
        if (accept) begin
            in0_d  = sel_pair[0];
            sel1_d = sel_pair[1];
            id_d   = grant_idx;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StReset;
            pc0_q       <= PhWait;
            cnt_q       <= '0;
            in0_q       <= 1'b0;
            in1_q       <= 1'b0;
            sel1_q      <= 1'b0;
            id_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc0_q       <= pc0_d;
            cnt_q       <= cnt_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            sel1_q      <= sel1_d;
            id_q        <= id_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
        end
    end

    assign req_ready = accept_win ? grant : '0;
    assign in0       = in0_q;
    assign in1       = in1_q;
    assign pc0       = 2'(pc0_q);
    assign pc1       = (state_q == StIdle) ? 2'(PhWait) : 2'(phase_prev(pc0_q));
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux4to1_sched.sv
// tb_mux4to1_sched: randomized bench for mux4to1_sched (N=4, P=2) with a
// slot-level reference model and an out_valid scoreboard.
module tb_mux4to1_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned P    = 2;
    localparam int unsigned IdxW = 2;

`ifdef MUXSCHED_IDLE_PARK_EN
    localparam bit Park = 1'b1;
`else
    localparam bit Park = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_sel;
    logic [N-1:0]    req_ready;
    logic            in0, in1;
    logic [1:0]      pc0, pc1;
    logic            out_valid;
    logic [IdxW-1:0] out_id;
    logic            busy;

    always #5 clk = ~clk;

    mux4to1_sched #(
        .N (N),
        .P (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .in0       (in0),
        .in1       (in1),
        .pc0       (pc0),
        .pc1       (pc1),
        .out_valid (out_valid),
        .out_id    (out_id),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_acc    = 0;

    // Reference model state
    bit         pend[N];
    logic [1:0] psel[N];
    int         rr;
    bit         idle;
    int         next_acc;
    bit         have_op;
    int         op_t;
    logic [1:0] op_sel;
    int         op_id;
    logic       m_in0, m_in1;
    int         m_out_id;
    int         mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        rr       = 0;
        idle     = Park;
        next_acc = P - 1;
        have_op  = 1'b0;
        m_in0    = 1'b0;
        m_in1    = 1'b0;
        m_out_id = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            psel[i] = 2'b00;
        end
        exp_q.delete();
    endtask

    task automatic check_reset();
        chk("rst_pc0", 32'(pc0), 0);
        chk("rst_pc1", 32'(pc1), Park ? 0 : 3);
        chk("rst_in0", 32'(in0), 0);
        chk("rst_in1", 32'(in1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        model_reset();
        #1;
        check_reset();
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            case (mode)
                1: if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    psel[i] = 2'($urandom_range(0, 3));
                end
                2: if (!pend[i]) begin
                    pend[i] = 1'b1;
                    psel[i] = 2'($urandom_range(0, 3));
                end
                3: if (i < 2) begin
                    pend[i] = 1'b1;
                    psel[i] = (i == 0) ? 2'b00 : 2'b11;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_sel[2*i +: 2]  = psel[i];
        end
    endtask

    // One clock cycle: drive, check against the slot model, advance.
    task automatic cycle();
        int         c;
        int         off;
        int         ep0, ep1;
        int         g;
        bit         win;
        bit         ebusy;
        logic [N-1:0] exp_ready;

        drive();
        #1;
        c = cyc;
        if (have_op && c == op_t + 1)         m_in0    = op_sel[0];
        if (have_op && c == op_t + P + 1)     m_in1    = op_sel[1];
        if (have_op && c == op_t + 2 * P + 1) m_out_id = op_id;

        if (idle) begin
            ep0 = 0;
            ep1 = 0;
        end else begin
            off = c - (next_acc - 4 * P);
            ep0 = ((off - 1) / P + 1) % 4;
            ep1 = (ep0 + 3) % 4;
        end
        ebusy = have_op && (c >= op_t + 1) && (c <= op_t + 4 * P);
        win   = idle || (c == next_acc);

        g = -1;
        exp_ready = '0;
        if (win) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;

        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("pc0", 32'(pc0), ep0);
        chk("pc1", 32'(pc1), ep1);
        chk("in0", 32'(in0), 32'(m_in0));
        chk("in1", 32'(in1), 32'(m_in1));
        chk("busy", 32'(busy), 32'(ebusy));
        chk("out_id_hold", 32'(out_id), m_out_id);

        if (g >= 0) begin
            exp_q.push_back('{id: g, due: c + 2 * P + 1});
            have_op  = 1'b1;
            op_t     = c;
            op_sel   = psel[g];
            op_id    = g;
            pend[g]  = 1'b0;
            rr       = (g + 1) % N;
            idle     = 1'b0;
            next_acc = c + 4 * P;
            n_acc++;
        end else if (win && !idle) begin
            if (Park) idle = 1'b1;
            else      next_acc = next_acc + 4 * P;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expectation whenever out_valid is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_unexpected", 32'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", 32'(out_id), e.id);
                    chk("out_valid_cycle", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("out_valid_at_due", 32'(out_valid), 1);
            end
        end
    end

    initial begin
        int guard;
        int start;
        rst_n     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        mode      = 0;
        @(negedge clk);

        // Reset and quiet period
        reset_dut();
        repeat (20) cycle();

        // Single request from requester 2, select {in1,in0} = 10
        pend[2] = 1'b1;
        psel[2] = 2'b10;
        repeat (12) cycle();

        // Full contention from rr = 0
        reset_dut();
        mode = 2;
        repeat (40) cycle();

        // Back-to-back alternating selects
        reset_dut();
        mode = 3;
        repeat (40) cycle();

        // Random traffic
        mode = 1;
        repeat (400) cycle();

        // Reset four cycles after an accept
        reset_dut();
        mode    = 0;
        pend[1] = 1'b1;
        psel[1] = 2'b11;
        start   = n_acc;
        guard   = 0;
        while (n_acc == start && guard < 20) begin
            cycle();
            guard++;
        end
        if (n_acc == start) begin
            n_checks++;
            n_err++;
            $display("FAIL midreset_accept: no grant within %0d cycles", guard);
        end
        repeat (3) cycle();
        reset_dut();
        repeat (12) cycle();

        // Random tail, then drain
        mode = 1;
        repeat (80) cycle();
        mode = 0;
        repeat (50) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
